muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that produces the HI/LO result pair for MULT, MULTU, DIV and DIVU. It sits beside the execute stage and holds the pipeline through `busy` while an operation runs. It returns the 64-bit result with a one-cycle `done` pulse, which the writeback stage uses to update HI/LO.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_div_step.sv | 19 +
 rtl/muldiv_ctrl.sv | 164 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Operation encoding: bit 1 selects divide, bit 0 selects unsigned.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

    localparam int DIV_ITERS = 32;

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Two's-complement magnitude; -2^31 maps to 0x80000000 as an unsigned value.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_radix2_step (
    input  logic [32:0] rem,
    input  logic [31:0] shift,
    input  logic [31:0] divisor,
    output logic [32:0] rem_next,
    output logic [31:0] shift_next
);

    logic [33:0] rem_sh;
    logic [33:0] diff;

    assign rem_sh     = {rem, shift[31]};
    assign diff       = rem_sh - {2'b00, divisor};
    assign rem_next   = diff[33] ? rem_sh[32:0] : diff[32:0];
    assign shift_next = {shift[30:0], ~diff[33]};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO with a one-cycle done pulse.
// Optional MULDIV_DIVZERO_FAST_EN: divide by zero completes directly from accept.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);

    localparam int CNT_MAX = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    muldiv_state_t    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    muldiv_op_t       op_reg;
    // For multiply: raw operands. For divide: dividend/quotient shift register and divisor magnitude.
    logic [31:0]      a_reg, b_reg;
    logic [32:0]      rem_reg;
    logic             neg_q_reg, neg_r_reg;
    logic [31:0]      hi_reg, lo_reg;

    logic             accept;
    logic             div_zero_fast;
    logic             mul_last, div_last;
    logic             load_result;
    logic [31:0]      res_hi, res_lo;
    logic             req_signed;

    logic [32:0]      step_rem;
    logic [31:0]      step_quo;
    logic [63:0]      a_ext, b_ext, product;

    assign accept     = bus.start && !bus.flush &&
                        (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign req_signed = is_signed_op(bus.op);
    assign mul_last   = (state_reg == ST_MUL) && (cnt_reg == MUL_LAST);
    assign div_last   = (state_reg == ST_DIV) && (cnt_reg == DIV_LAST);

`ifdef MULDIV_DIVZERO_FAST_EN
    assign div_zero_fast = accept && is_div(bus.op) && (bus.b == 32'd0);
`else
    assign div_zero_fast = 1'b0;
`endif

    div_radix2_step u_step (
        .rem        (rem_reg),
        .shift      (a_reg),
        .divisor    (b_reg),
        .rem_next   (step_rem),
        .shift_next (step_quo)
    );

    // Sign-extending to 64 bits makes one unsigned 64x64 product serve both MULT and MULTU.
    assign a_ext   = {{32{is_signed_op(op_reg) & a_reg[31]}}, a_reg};
    assign b_ext   = {{32{is_signed_op(op_reg) & b_reg[31]}}, b_reg};
    assign product = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (!accept) begin
                    state_next = ST_IDLE;
                end else if (div_zero_fast) begin
                    state_next = ST_DONE;
                end else if (is_div(bus.op)) begin
                    state_next = ST_DIV;
                end else begin
                    state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else if (mul_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else if (div_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_reg == ST_MUL) || (state_reg == ST_DIV);
        bus.done = (state_reg == ST_DONE);
        bus.hi   = hi_reg;
        bus.lo   = lo_reg;
    end

    // The last divide iteration's output feeds the sign fix-up directly, saving a cycle.
    always_comb begin
        load_result = 1'b0;
        res_hi      = hi_reg;
        res_lo      = lo_reg;
        if (!bus.flush && mul_last) begin
            load_result = 1'b1;
            res_hi      = product[63:32];
            res_lo      = product[31:0];
        end else if (!bus.flush && div_last) begin
            load_result = 1'b1;
            res_hi      = neg_r_reg ? (32'd0 - step_rem[31:0]) : step_rem[31:0];
            res_lo      = neg_q_reg ? (32'd0 - step_quo) : step_quo;
        end else if (div_zero_fast) begin
            load_result = 1'b1;
            res_hi      = bus.a;
            res_lo      = (req_signed && bus.a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            op_reg    <= OP_MULT;
            a_reg     <= '0;
            b_reg     <= '0;
            rem_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            if (accept) begin
                cnt_reg   <= '0;
                op_reg    <= bus.op;
                rem_reg   <= '0;
                a_reg     <= is_div(bus.op) ? abs32(bus.a, req_signed) : bus.a;
                b_reg     <= is_div(bus.op) ? abs32(bus.b, req_signed) : bus.b;
                neg_q_reg <= req_signed && (bus.a[31] ^ bus.b[31]);
                neg_r_reg <= req_signed && bus.a[31];
            end else if (state_reg == ST_MUL) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (state_reg == ST_DIV) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                rem_reg <= step_rem;
                a_reg   <= step_quo;
            end
            if (load_result) begin
                hi_reg <= res_hi;
                lo_reg <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: latency-countdown reference model compared every cycle,
// plus directed scenarios with hand-computed HI/LO values and completion cycles.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 3;
`ifdef MULDIV_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input muldiv_op_t op, input logic [31:0] a,
                                               input logic [31:0] b);
        int     ia, ib, q, r;
        longint la, lb;
        ia = a;
        ib = b;
        la = ia;
        lb = ib;
        case (op)
            OP_MULT:  return la * lb;
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_DIV: begin
                if (b == 32'd0) return {a, (ia < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input muldiv_op_t op, input logic [31:0] b);
        if (op == OP_MULT || op == OP_MULTU) return MUL_LAT;
        if (FAST && b == 32'd0) return 0;
        return DIV_ITERS;
    endfunction

    // Model: cycles of busy remaining, pending result, and the visible HI/LO/done.
    int          m_left;
    logic [63:0] m_pend;
    logic        e_done;
    logic [31:0] e_hi, e_lo;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_pend <= '0;
            e_done <= 1'b0;
            e_hi   <= '0;
            e_lo   <= '0;
        end else if (m_left > 0) begin
            e_done <= 1'b0;
            if (bus.flush) begin
                m_left <= 0;
            end else if (m_left == 1) begin
                m_left <= 0;
                e_done <= 1'b1;
                {e_hi, e_lo} <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else begin
            e_done <= 1'b0;
            if (bus.start && !bus.flush) begin
                if (ref_lat(bus.op, bus.b) == 0) begin
                    e_done <= 1'b1;
                    {e_hi, e_lo} <= ref_result(bus.op, bus.a, bus.b);
                end else begin
                    m_left <= ref_lat(bus.op, bus.b);
                    m_pend <= ref_result(bus.op, bus.a, bus.b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
            check("cyc_done", 64'(bus.done), 64'(e_done));
            check("cyc_hi",   64'(bus.hi),   64'(e_hi));
            check("cyc_lo",   64'(bus.lo),   64'(e_lo));
        end
    end

    // Caller is at posedge+#1; after return the accept edge has passed (now in cycle 1).
    task automatic go(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, input int exp_cyc, input string name);
        int cyc = cyc0;
        while (!bus.done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic check_hilo(input string name, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo);
        check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        step_cycles(2);
        cmp_en = 1'b1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check_hilo("rst", 32'd0, 32'd0);
        reset = 1'b0;
        step_cycles(1);

        go(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_busy_c1", 64'(bus.busy), 64'd1);
        wait_done(1, 4, "mult");
        check("mult_busy_done", 64'(bus.busy), 64'd0);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        $display("MULT  -3*5          hi=%08h lo=%08h", bus.hi, bus.lo);

        go(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, 4, "multu");
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        $display("MULTU ffffffff^2    hi=%08h lo=%08h", bus.hi, bus.lo);
        step_cycles(1);

        go(OP_DIVU, 32'd100, 32'd7);
        wait_done(1, 33, "divu");
        check_hilo("divu", 32'd2, 32'd14);
        $display("DIVU  100/7         hi=%08h lo=%08h", bus.hi, bus.lo);
        go(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, 33, "div_b2b");
        check_hilo("div_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        $display("DIV   -7/2 (b2b)    hi=%08h lo=%08h", bus.hi, bus.lo);
        step_cycles(1);

        go(OP_DIVU, 32'd5, 32'd0);
        wait_done(1, FAST ? 1 : 33, "divu_z");
        check_hilo("divu_z", 32'd5, 32'hFFFF_FFFF);
        $display("DIVU  5/0           hi=%08h lo=%08h", bus.hi, bus.lo);
        go(OP_DIV, 32'h8000_0000, 32'd0);
        wait_done(1, FAST ? 1 : 33, "div_z");
        check_hilo("div_z", 32'h8000_0000, 32'h0000_0001);
        $display("DIV   80000000/0    hi=%08h lo=%08h", bus.hi, bus.lo);
        step_cycles(1);

        go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, 33, "div_ovf");
        check_hilo("div_ovf", 32'd0, 32'h8000_0000);
        $display("DIV   -2^31/-1      hi=%08h lo=%08h", bus.hi, bus.lo);
        step_cycles(1);

        go(OP_DIV, 32'd12345, 32'd6);
        step_cycles(9);
        bus.flush = 1'b1;
        step_cycles(1);
        bus.flush = 1'b0;
        check("flush_busy_c11", 64'(bus.busy), 64'd0);
        check("flush_done_c11", 64'(bus.done), 64'd0);
        check_hilo("flush_hold", 32'd0, 32'h8000_0000);
        $display("FLUSH at cycle 10   hi=%08h lo=%08h busy=%0b", bus.hi, bus.lo, bus.busy);
        go(OP_DIVU, 32'd1000, 32'd10);
        check("post_flush_busy", 64'(bus.busy), 64'd1);
        wait_done(1, 33, "post_flush");
        check_hilo("post_flush", 32'd0, 32'd100);
        $display("DIVU  1000/10       hi=%08h lo=%08h", bus.hi, bus.lo);
        step_cycles(1);

        go(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        step_cycles(4);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        step_cycles(1);
        bus.start = 1'b0;
        wait_done(6, 33, "ignored_start");
        check_hilo("ignored_start", 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        $display("DIV   -100/7 (ign)  hi=%08h lo=%08h", bus.hi, bus.lo);
        step_cycles(1);
        check("single_done", 64'(bus.done), 64'd0);

        go(OP_DIVU, 32'd77, 32'd5);
        step_cycles(19);
        reset = 1'b1;
        step_cycles(1);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check_hilo("midrst", 32'd0, 32'd0);
        $display("RESET at cycle 20   hi=%08h lo=%08h busy=%0b", bus.hi, bus.lo, bus.busy);
        reset = 1'b0;
        step_cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
